// File: rtl/axi_lite_csr_subordinate.sv
// AXI-lite CSR subordinate: byte-wide R/W register file on the CSR bus.
// Optional macro CSR_ERR_RESP_EN: SLVERR on out-of-range accesses.
module axi_lite_csr_subordinate #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 16
) (
  input  logic                           csr_clk,
  input  logic                           csr_resetn,
  input  logic [ADDR_WIDTH-1:0]          csr_awaddr,
  input  logic                           csr_awvalid,
  output logic                           csr_awready,
  input  logic [DATA_WIDTH-1:0]          csr_wdata,
  input  logic                           csr_wvalid,
  output logic                           csr_wready,
  input  logic                           csr_wlast,
  output logic [1:0]                     csr_bresp,
  output logic                           csr_bvalid,
  input  logic                           csr_bready,
  input  logic [ADDR_WIDTH-1:0]          csr_araddr,
  input  logic                           csr_arvalid,
  output logic                           csr_arready,
  output logic [DATA_WIDTH-1:0]          csr_rdata,
  output logic [1:0]                     csr_rresp,
  output logic                           csr_rvalid,
  input  logic                           csr_rready,
  output logic                           csr_rlast,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);

  localparam int IDX_W =
    (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef CSR_ERR_RESP_EN
  localparam logic [1:0] RESP_OOR = 2'b10;
`else
  localparam logic [1:0] RESP_OOR = 2'b00;
`endif

  typedef enum logic {
    W_IDLE,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } r_state_e;

  function automatic logic in_range(
    input logic [ADDR_WIDTH-1:0] a
  );
    return {1'b0, a} <
      (ADDR_WIDTH+1)'(NUM_REGS);
  endfunction

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_d;

  w_state_e              w_state_q, w_state_d;
  logic                  aw_cap_q, aw_cap_d;
  logic                  w_cap_q, w_cap_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;

  r_state_e              r_state_q, r_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  unused_wlast;

  assign aw_hs = csr_awvalid & awready_q;
  assign w_hs  = csr_wvalid & wready_q;
  assign ar_hs = csr_arvalid & arready_q;

  // A beat captured on this very edge bypasses
  // its holding register.
  assign wr_addr = aw_hs ? csr_awaddr : awaddr_q;
  assign wr_data = w_hs ? csr_wdata : wdata_q;

  assign unused_wlast = csr_wlast;

  // Write channel: independent AW/W capture,
  // commit on the edge both are held, then B.
  always_comb begin
    w_state_d = w_state_q;
    aw_cap_d  = aw_cap_q;
    w_cap_d   = w_cap_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_cap_d = 1'b1;
          awaddr_d = csr_awaddr;
        end
        if (w_hs) begin
          w_cap_d = 1'b1;
          wdata_d = csr_wdata;
        end
        if (aw_cap_d && w_cap_d) begin
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          if (in_range(wr_addr)) begin
            regs_d[wr_addr[IDX_W-1:0]] = wr_data;
            bresp_d = RESP_OKAY;
          end else begin
            bresp_d = RESP_OOR;
          end
        end else begin
          awready_d = !aw_cap_d;
          wready_d  = !w_cap_d;
        end
      end
      W_RESP: begin
        if (csr_bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          aw_cap_d  = 1'b0;
          w_cap_d   = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write channel and register file state.
  always_ff @(posedge csr_clk or negedge csr_resetn) begin
    if (!csr_resetn) begin
      w_state_q <= W_IDLE;
      aw_cap_q  <= 1'b0;
      w_cap_q   <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      regs_q    <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_cap_q  <= aw_cap_d;
      w_cap_q   <= w_cap_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      regs_q    <= regs_d;
    end
  end

  // Read channel: latch data on AR, hold R
  // until accepted. Reads see pre-commit data.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    unique case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          r_state_d = R_RESP;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          if (in_range(csr_araddr)) begin
            rdata_d = regs_q[csr_araddr[IDX_W-1:0]];
            rresp_d = RESP_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = RESP_OOR;
          end
        end
      end
      R_RESP: begin
        if (csr_rready) begin
          r_state_d = R_IDLE;
          arready_d = 1'b1;
          rvalid_d  = 1'b0;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read channel state.
  always_ff @(posedge csr_clk or negedge csr_resetn) begin
    if (!csr_resetn) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign csr_awready = awready_q;
  assign csr_wready  = wready_q;
  assign csr_bvalid  = bvalid_q;
  assign csr_bresp   = bresp_q;
  assign csr_arready = arready_q;
  assign csr_rvalid  = rvalid_q;
  assign csr_rlast   = rvalid_q;
  assign csr_rresp   = rresp_q;
  assign csr_rdata   = rdata_q;
  assign regs_out    = regs_q;

endmodule

// File: tb/tb_axi_lite_csr_subordinate.sv
// Scoreboard bench for axi_lite_csr_subordinate.
// Random and directed traffic vs. a register-array model.
module tb_axi_lite_csr_subordinate;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int NR = 16;
`ifdef CSR_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic           csr_clk;
  logic           csr_resetn;
  logic [AW-1:0]  csr_awaddr;
  logic           csr_awvalid;
  logic           csr_awready;
  logic [DW-1:0]  csr_wdata;
  logic           csr_wvalid;
  logic           csr_wready;
  logic           csr_wlast;
  logic [1:0]     csr_bresp;
  logic           csr_bvalid;
  logic           csr_bready;
  logic [AW-1:0]  csr_araddr;
  logic           csr_arvalid;
  logic           csr_arready;
  logic [DW-1:0]  csr_rdata;
  logic [1:0]     csr_rresp;
  logic           csr_rvalid;
  logic           csr_rready;
  logic           csr_rlast;
  logic [NR*DW-1:0] regs_out;

  axi_lite_csr_subordinate #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_REGS(NR)
  ) dut (
    .csr_clk(csr_clk),
    .csr_resetn(csr_resetn),
    .csr_awaddr(csr_awaddr),
    .csr_awvalid(csr_awvalid),
    .csr_awready(csr_awready),
    .csr_wdata(csr_wdata),
    .csr_wvalid(csr_wvalid),
    .csr_wready(csr_wready),
    .csr_wlast(csr_wlast),
    .csr_bresp(csr_bresp),
    .csr_bvalid(csr_bvalid),
    .csr_bready(csr_bready),
    .csr_araddr(csr_araddr),
    .csr_arvalid(csr_arvalid),
    .csr_arready(csr_arready),
    .csr_rdata(csr_rdata),
    .csr_rresp(csr_rresp),
    .csr_rvalid(csr_rvalid),
    .csr_rready(csr_rready),
    .csr_rlast(csr_rlast),
    .regs_out(regs_out)
  );

  initial csr_clk = 1'b0;
  always #5 csr_clk = ~csr_clk;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] r;
  } rexp_t;

  int n_cmp = 0;
  int n_fail = 0;
  logic [1:0] bq[$];
  rexp_t rq[$];
  logic [7:0] model[NR];
  int rdy_mode = 1;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [1:0] exp_resp(input int a);
    return (a >= NR && ERR_EN) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [7:0] exp_rdata(input int a);
    return (a < NR) ? model[a] : 8'h00;
  endfunction

  function automatic logic [127:0] model_vec();
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < NR; i++) v[i*8 +: 8] = model[i];
    return v;
  endfunction

  function automatic logic rdy(input int ch);
    case (ch)
      0: return csr_awready;
      1: return csr_wready;
      default: return csr_arready;
    endcase
  endfunction

  // Response-ready driver: random, held low, or held high.
  initial begin
    csr_bready = 1'b0;
    csr_rready = 1'b0;
    forever begin
      @(posedge csr_clk);
      #1;
      case (rdy_mode)
        0: begin
          csr_bready = ($urandom_range(0, 3) != 0);
          csr_rready = ($urandom_range(0, 3) != 0);
        end
        1: begin
          csr_bready = 1'b0;
          csr_rready = 1'b0;
        end
        default: begin
          csr_bready = 1'b1;
          csr_rready = 1'b1;
        end
      endcase
    end
  end

  // Monitor: pops the scoreboard on each B/R handshake
  // and checks held responses do not change.
  logic       b_hold = 1'b0;
  logic [1:0] b_prev;
  logic       r_hold = 1'b0;
  rexp_t      r_prev;
  always @(negedge csr_clk) begin
    if (!csr_resetn) begin
      b_hold = 1'b0;
      r_hold = 1'b0;
    end else begin
      if (csr_bvalid) begin
        if (b_hold) chk("bresp_stable", csr_bresp, b_prev);
        if (csr_bready) begin
          b_hold = 1'b0;
          if (bq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL b_unexpected: bresp %0h", csr_bresp);
          end else begin
            chk("bresp", csr_bresp, bq.pop_front());
          end
        end else begin
          b_hold = 1'b1;
          b_prev = csr_bresp;
        end
      end else begin
        b_hold = 1'b0;
      end
      if (csr_rvalid) begin
        if (r_hold)
          chk("r_stable", {csr_rdata, csr_rresp}, r_prev);
        if (csr_rready) begin
          r_hold = 1'b0;
          chk("rlast", csr_rlast, 1'b1);
          if (rq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL r_unexpected: rdata %0h", csr_rdata);
          end else begin
            chk("rdata_rresp", {csr_rdata, csr_rresp},
                rq.pop_front());
          end
        end else begin
          r_hold = 1'b1;
          r_prev = {csr_rdata, csr_rresp};
        end
      end else begin
        r_hold = 1'b0;
      end
    end
  end

  task automatic send(input int ch, input logic [7:0] v,
                      input int d);
    int n;
    repeat (d) @(posedge csr_clk);
    #1;
    case (ch)
      0: begin csr_awaddr = v; csr_awvalid = 1'b1; end
      1: begin csr_wdata = v; csr_wvalid = 1'b1; end
      default: begin csr_araddr = v; csr_arvalid = 1'b1; end
    endcase
    n = 0;
    @(negedge csr_clk);
    while (!rdy(ch) && n < 100) begin
      @(negedge csr_clk);
      n++;
    end
    if (n >= 100) chk("ready_timeout", ch, 99);
    @(posedge csr_clk);
    #1;
    case (ch)
      0: csr_awvalid = 1'b0;
      1: csr_wvalid = 1'b0;
      default: csr_arvalid = 1'b0;
    endcase
  endtask

  task automatic wait_b();
    int n;
    n = 0;
    @(negedge csr_clk);
    while (!(csr_bvalid && csr_bready) && n < 200) begin
      @(negedge csr_clk);
      n++;
    end
    if (n >= 200) chk("b_timeout", csr_bvalid, 1'bx);
    @(posedge csr_clk);
    #1;
  endtask

  task automatic wait_r();
    int n;
    n = 0;
    @(negedge csr_clk);
    while (!(csr_rvalid && csr_rready) && n < 200) begin
      @(negedge csr_clk);
      n++;
    end
    if (n >= 200) chk("r_timeout", csr_rvalid, 1'bx);
    @(posedge csr_clk);
    #1;
  endtask

  task automatic do_write(input int a, input logic [7:0] d,
                          input int daw, input int dw);
    bq.push_back(exp_resp(a));
    fork
      send(0, 8'(a), daw);
      send(1, d, dw);
    join
    wait_b();
    if (a < NR) model[a] = d;
    chk("regs_out", regs_out, model_vec());
  endtask

  task automatic do_read(input int a);
    rq.push_back({exp_rdata(a), exp_resp(a)});
    send(2, 8'(a), 0);
    wait_r();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    csr_resetn  = 1'b0;
    csr_awaddr  = '0;
    csr_awvalid = 1'b0;
    csr_wdata   = '0;
    csr_wvalid  = 1'b0;
    csr_wlast   = 1'b1;
    csr_araddr  = '0;
    csr_arvalid = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = 8'h00;

    repeat (3) @(negedge csr_clk);
    chk("reset_outs",
        {csr_awready, csr_wready, csr_bresp, csr_bvalid,
         csr_arready, csr_rdata, csr_rresp, csr_rvalid,
         csr_rlast}, 18'h0);
    chk("reset_regs", regs_out, 128'h0);
    csr_resetn = 1'b1;
    #1;
    chk("rdy_pre_edge",
        {csr_awready, csr_wready, csr_arready}, 3'b000);
    @(posedge csr_clk);
    #1;
    chk("rdy_post_edge",
        {csr_awready, csr_wready, csr_arready}, 3'b111);

    rdy_mode = 2;
    do_write(5, 8'hA5, 0, 0);
    chk("reg5", regs_out[47:40], 8'hA5);
    do_read(5);

    // W at t, AW at t+3, bvalid after edge t+4.
    rdy_mode = 1;
    bq.push_back(2'b00);
    @(posedge csr_clk);
    #1;
    csr_wdata = 8'h3C;
    csr_wvalid = 1'b1;
    @(negedge csr_clk);
    chk("wready_t0", csr_wready, 1'b1);
    @(posedge csr_clk);
    #1;
    csr_wvalid = 1'b0;
    @(negedge csr_clk);
    chk("wready_drop", {csr_wready, csr_awready}, 2'b01);
    @(posedge csr_clk);
    @(posedge csr_clk);
    #1;
    csr_awaddr = 8'h02;
    csr_awvalid = 1'b1;
    @(negedge csr_clk);
    chk("bvalid_t3", csr_bvalid, 1'b0);
    @(posedge csr_clk);
    #1;
    csr_awvalid = 1'b0;
    @(negedge csr_clk);
    chk("bvalid_t4", csr_bvalid, 1'b1);
    rdy_mode = 2;
    wait_b();
    model[2] = 8'h3C;
    chk("reg2", regs_out, model_vec());

    // Backpressure on both response channels.
    rdy_mode = 1;
    @(posedge csr_clk);
    #1;
    bq.push_back(2'b00);
    rq.push_back({model[5], 2'b00});
    fork
      send(0, 8'h07, 0);
      send(1, 8'h5A, 0);
      send(2, 8'h05, 0);
    join
    csr_awvalid = 1'b1;
    csr_arvalid = 1'b1;
    csr_awaddr  = 8'h09;
    csr_araddr  = 8'h09;
    repeat (5) begin
      @(negedge csr_clk);
      chk("bp_valids", {csr_bvalid, csr_rvalid}, 2'b11);
      chk("bp_readies", {csr_awready, csr_arready}, 2'b00);
    end
    csr_awvalid = 1'b0;
    csr_arvalid = 1'b0;
    rdy_mode = 2;
    fork
      wait_b();
      wait_r();
    join
    model[7] = 8'h5A;
    chk("reg7", regs_out, model_vec());

    // Collision: commit and AR on the same edge.
    do_write(1, 8'h11, 0, 0);
    bq.push_back(2'b00);
    rq.push_back({8'h11, 2'b00});
    fork
      send(0, 8'h01, 0);
      send(1, 8'h22, 0);
      send(2, 8'h01, 0);
    join
    fork
      wait_b();
      wait_r();
    join
    model[1] = 8'h22;
    chk("reg1", regs_out, model_vec());
    do_read(1);

    // Out-of-range access.
    do_write(8'h40, 8'hFF, 1, 0);
    do_read(8'h40);
    do_read(NR);

    // Randomized traffic with random response backpressure.
    rdy_mode = 0;
    for (int it = 0; it < 80; it++) begin
      int a;
      a = ($urandom_range(0, 7) == 0) ?
          int'($urandom_range(0, 255)) :
          int'($urandom_range(0, NR - 1));
      if ($urandom_range(0, 1) == 0)
        do_write(a, 8'($urandom),
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)));
      else
        do_read(a);
    end

    // Reset with a pending B and R response.
    rdy_mode = 1;
    @(posedge csr_clk);
    #1;
    fork
      send(0, 8'h03, 0);
      send(1, 8'h77, 0);
      send(2, 8'h03, 0);
    join
    @(negedge csr_clk);
    chk("pend_valids", {csr_bvalid, csr_rvalid}, 2'b11);
    #2;
    csr_resetn = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) model[i] = 8'h00;
    chk("midrst_outs",
        {csr_awready, csr_wready, csr_bresp, csr_bvalid,
         csr_arready, csr_rdata, csr_rresp, csr_rvalid,
         csr_rlast}, 18'h0);
    chk("midrst_regs", regs_out, model_vec());
    @(negedge csr_clk);
    csr_resetn = 1'b1;
    rdy_mode = 2;
    @(posedge csr_clk);
    #1;
    do_read(3);
    do_read(5);

    repeat (4) @(posedge csr_clk);
    chk("bq_empty", bq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
